// File: rtl/bounce_gen.sv
// Switch-bounce emulator: chatters bounce_out for BOUNCE cycles after each level_in edge, then settles.
// Optional macro BOUNCE_GEN_DECAY_EN makes the second half of each window decay toward the target.
module bounce_gen #(
  parameter int          W      = 16,
  parameter int          BOUNCE = 50000,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic bounce_out,
  output logic busy,
  output logic settle_tick
);

  // state     | meaning
  // IDLE0     | settled low, waiting for level_in=1
  // BOUNCE_UP | chattering toward 1
  // IDLE1     | settled high, waiting for level_in=0
  // BOUNCE_DN | chattering toward 0
  localparam logic [1:0] IDLE0     = 2'd0;
  localparam logic [1:0] BOUNCE_UP = 2'd1;
  localparam logic [1:0] IDLE1     = 2'd2;
  localparam logic [1:0] BOUNCE_DN = 2'd3;

  localparam logic [W-1:0] CNT_LOAD = W'(BOUNCE - 1);
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
`ifdef BOUNCE_GEN_DECAY_EN
  localparam logic [W-1:0] CNT_HALF = W'(BOUNCE / 2);
`endif

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic         bounce_q, bounce_d;
  logic         busy_q, busy_d;
  logic         tick_q, tick_d;
  logic         target;
  logic         chatter_en;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign target = (state_q == BOUNCE_UP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bounce_d   = bounce_q;
    busy_d     = busy_q;
    tick_d     = 1'b0;
    chatter_en = 1'b0;
    case (state_q)
      IDLE0: begin
        if (level_in) begin
          state_d    = BOUNCE_UP;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          chatter_en = 1'b1;
        end
      end
      IDLE1: begin
        if (!level_in) begin
          state_d    = BOUNCE_DN;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          chatter_en = 1'b1;
        end
      end
      BOUNCE_UP, BOUNCE_DN: begin
        if (level_in != target) begin
          state_d    = (state_q == BOUNCE_UP) ? BOUNCE_DN : BOUNCE_UP;
          cnt_d      = CNT_LOAD;
          chatter_en = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d      = cnt_q - CNT_ONE;
          chatter_en = 1'b1;
        end else begin
          bounce_d = target;
          busy_d   = 1'b0;
          tick_d   = 1'b1;
          state_d  = (state_q == BOUNCE_UP) ? IDLE1 : IDLE0;
        end
      end
      default: state_d = IDLE0;
    endcase

    // Whenever chatter is produced, level_in already equals the new window's target.
    if (chatter_en) begin
`ifdef BOUNCE_GEN_DECAY_EN
      if (cnt_d < CNT_HALF) begin
        bounce_d = (lfsr_q[1:0] == 2'b00) ? ~level_in : level_in;
      end else begin
        bounce_d = lfsr_q[0];
      end
`else
      bounce_d = lfsr_q[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE0;
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      bounce_q <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      bounce_q <= bounce_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
    end
  end

  assign bounce_out  = bounce_q;
  assign busy        = busy_q;
  assign settle_tick = tick_q;

endmodule
